// File: rtl/inst_queue_pkg.sv
// rtl/inst_queue_pkg.sv - shared widths, entry layout and dequeue clamp for the instruction queue
package inst_queue_pkg;

    localparam int PC_W     = 32;
    localparam int INST_W   = 32;
    localparam int IQ_DEPTH = 8;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   npc;
        logic [INST_W-1:0] inst;
    } iq_entry_t;

    // req=3 is not a legal decode request and consumes nothing
    function automatic logic [1:0] deq_clamp(input logic [1:0] req, input logic [1:0] avail);
        if (req == 2'd3) return 2'd0;
        return (req < avail) ? req : avail;
    endfunction

endpackage

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - dual-issue circular instruction queue between fetch and decode
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in1_valid,
    input  logic                       in2_valid,
    input  logic [PC_W-1:0]            in1_pc,
    input  logic [PC_W-1:0]            in1_npc,
    input  logic [INST_W-1:0]          in1_inst,
    input  logic [PC_W-1:0]            in2_pc,
    input  logic [PC_W-1:0]            in2_npc,
    input  logic [INST_W-1:0]          in2_inst,
    output logic                       in_ready,
    output logic                       out1_valid,
    output logic                       out2_valid,
    output logic [PC_W-1:0]            out1_pc,
    output logic [PC_W-1:0]            out1_npc,
    output logic [INST_W-1:0]          out1_inst,
    output logic [PC_W-1:0]            out2_pc,
    output logic [PC_W-1:0]            out2_npc,
    output logic [INST_W-1:0]          out2_inst,
    input  logic [1:0]                 deq_num,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    iq_entry_t     mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count_q;
    logic [1:0]    wr_num;
    logic [1:0]    avail;
    logic [1:0]    deq_eff;
    iq_entry_t     head0;
    iq_entry_t     head1;

    // Readiness uses only the registered occupancy so fetch never depends on decode's same-cycle consume
    assign in_ready = (count_q <= CW'(DEPTH - 2));

    always_comb begin
        wr_num = 2'd0;
        if (in_ready && in1_valid) begin
            wr_num = in2_valid ? 2'd2 : 2'd1;
        end
        avail   = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
        deq_eff = deq_clamp(deq_num, avail);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (wr_num != 2'd0) begin
                mem[tail] <= '{pc: in1_pc, npc: in1_npc, inst: in1_inst};
            end
            if (wr_num == 2'd2) begin
                mem[tail + PW'(1)] <= '{pc: in2_pc, npc: in2_npc, inst: in2_inst};
            end
            tail    <= tail + PW'(wr_num);
            head    <= head + PW'(deq_eff);
            count_q <= count_q + CW'(wr_num) - CW'(deq_eff);
        end
    end

    assign head0 = mem[head];
    assign head1 = mem[head + PW'(1)];

    assign count      = count_q;
    assign out1_valid = (count_q >= CW'(1));
    assign out2_valid = (count_q >= CW'(2));
    assign out1_pc    = head0.pc;
    assign out1_npc   = head0.npc;
    assign out1_inst  = head0.inst;
    assign out2_pc    = head1.pc;
    assign out2_npc   = head1.npc;
    assign out2_inst  = head1.inst;

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - randomized and directed bench for inst_queue against a queue-based model
module tb_inst_queue;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in1_valid = 1'b0;
    logic        in2_valid = 1'b0;
    logic [31:0] in1_pc = '0, in1_npc = '0, in1_inst = '0;
    logic [31:0] in2_pc = '0, in2_npc = '0, in2_inst = '0;
    logic        in_ready;
    logic        out1_valid, out2_valid;
    logic [31:0] out1_pc, out1_npc, out1_inst;
    logic [31:0] out2_pc, out2_npc, out2_inst;
    logic [1:0]  deq_num = 2'd0;
    logic        flush = 1'b0;
    logic [3:0]  count;

    int   n_checks = 0;
    int   n_fail   = 0;
    ent_t q[$];

    inst_queue #(.DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .in1_valid(in1_valid), .in2_valid(in2_valid),
        .in1_pc(in1_pc), .in1_npc(in1_npc), .in1_inst(in1_inst),
        .in2_pc(in2_pc), .in2_npc(in2_npc), .in2_inst(in2_inst),
        .in_ready(in_ready),
        .out1_valid(out1_valid), .out2_valid(out2_valid),
        .out1_pc(out1_pc), .out1_npc(out1_npc), .out1_inst(out1_inst),
        .out2_pc(out2_pc), .out2_npc(out2_npc), .out2_inst(out2_inst),
        .deq_num(deq_num), .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int sz = q.size();
        check_eq("count", 64'(count), 64'(sz));
        check_eq("in_ready", 64'(in_ready), 64'(8 - sz >= 2));
        check_eq("out1_valid", 64'(out1_valid), 64'(sz >= 1));
        check_eq("out2_valid", 64'(out2_valid), 64'(sz >= 2));
        if (sz >= 1) begin
            check_eq("out1_pc", 64'(out1_pc), 64'(q[0].pc));
            check_eq("out1_npc", 64'(out1_npc), 64'(q[0].npc));
            check_eq("out1_inst", 64'(out1_inst), 64'(q[0].inst));
        end
        if (sz >= 2) begin
            check_eq("out2_pc", 64'(out2_pc), 64'(q[1].pc));
            check_eq("out2_npc", 64'(out2_npc), 64'(q[1].npc));
            check_eq("out2_inst", 64'(out2_inst), 64'(q[1].inst));
        end
    endtask

    // Model one clock edge from the architectural rules, then compare on the falling edge
    task automatic cycle(input bit v1, input bit v2, input logic [31:0] p1, input logic [31:0] p2,
                         input logic [1:0] dq, input bit fl);
        bit ready;
        int take;
        in1_valid = v1;
        in2_valid = v2;
        in1_pc = p1; in1_npc = p1 + 32'd4; in1_inst = $urandom;
        in2_pc = p2; in2_npc = p2 + 32'd4; in2_inst = $urandom;
        deq_num = dq;
        flush = fl;
        @(posedge clk);
        ready = (8 - q.size() >= 2);
        if (fl) begin
            q.delete();
        end else begin
            take = (dq == 2'd3) ? 0 : ((int'(dq) < q.size()) ? int'(dq) : q.size());
            repeat (take) void'(q.pop_front());
            if (ready && v1) begin
                q.push_back('{pc: in1_pc, npc: in1_npc, inst: in1_inst});
                if (v2) q.push_back('{pc: in2_pc, npc: in2_npc, inst: in2_inst});
            end
        end
        @(negedge clk);
        in1_valid = 1'b0; in2_valid = 1'b0; deq_num = 2'd0; flush = 1'b0;
        check_all();
    endtask

    task automatic idle();
        cycle(0, 0, 32'h0, 32'h0, 2'd0, 0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        q.delete();
        for (int i = 0; i < n; i++) begin
            in1_valid = 1'($urandom); in2_valid = 1'($urandom);
            in1_pc = $urandom; in2_pc = $urandom; in1_inst = $urandom; in2_inst = $urandom;
            deq_num = 2'($urandom); flush = 1'($urandom);
            @(negedge clk);
            check_eq("rst_count", 64'(count), 64'd0);
            check_eq("rst_in_ready", 64'(in_ready), 64'd1);
            check_eq("rst_out1_valid", 64'(out1_valid), 64'd0);
            check_eq("rst_out2_valid", 64'(out2_valid), 64'd0);
            check_eq("rst_out1_data", {out1_pc, out1_npc | out1_inst}, 64'd0);
            check_eq("rst_out2_data", {out2_pc, out2_npc | out2_inst}, 64'd0);
        end
        in1_valid = 1'b0; in2_valid = 1'b0; deq_num = 2'd0; flush = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        @(negedge clk);
        do_reset(3);

        // ordering
        cycle(1, 1, 32'h00, 32'h04, 2'd0, 0);
        cycle(1, 1, 32'h08, 32'h0C, 2'd0, 0);
        cycle(1, 1, 32'h10, 32'h14, 2'd0, 0);
        for (int i = 0; i < 6; i++) begin
            check_eq("order_pc", 64'(out1_pc), 64'(i * 4));
            cycle(0, 0, 32'h0, 32'h0, 2'd1, 0);
        end
        check_eq("order_empty", 64'(count), 64'd0);

        // full, refused pair, wrap
        for (int i = 0; i < 4; i++) cycle(1, 1, 32'h100 + 32'(i * 8), 32'h104 + 32'(i * 8), 2'd0, 0);
        check_eq("full_count", 64'(count), 64'd8);
        check_eq("full_ready", 64'(in_ready), 64'd0);
        cycle(1, 1, 32'h900, 32'h904, 2'd2, 0);
        check_eq("full_deq_count", 64'(count), 64'd6);
        for (int i = 0; i < 12; i++) cycle(1, 1, 32'h200 + 32'(i * 8), 32'h204 + 32'(i * 8), 2'd2, 0);
        repeat (5) cycle(0, 0, 32'h0, 32'h0, 2'd2, 0);
        check_eq("wrap_drained", 64'(count), 64'd0);

        // over-dequeue clamp and deq_num=3
        cycle(1, 0, 32'h300, 32'h0, 2'd0, 0);
        cycle(0, 0, 32'h0, 32'h0, 2'd2, 0);
        check_eq("clamp_count", 64'(count), 64'd0);
        cycle(1, 1, 32'h310, 32'h314, 2'd0, 0);
        cycle(1, 1, 32'h318, 32'h31C, 2'd0, 0);
        cycle(0, 0, 32'h0, 32'h0, 2'd3, 0);
        check_eq("deq3_count", 64'(count), 64'd4);

        // flush priority at count=5
        cycle(1, 0, 32'h320, 32'h0, 2'd0, 0);
        check_eq("pre_flush_count", 64'(count), 64'd5);
        cycle(1, 1, 32'h330, 32'h334, 2'd2, 1);
        check_eq("flush_count", 64'(count), 64'd0);
        check_eq("flush_v1", 64'(out1_valid), 64'd0);
        check_eq("flush_ready", 64'(in_ready), 64'd1);

        // single-slot write and illegal slot-2-only
        cycle(1, 0, 32'h40, 32'h0, 2'd0, 0);
        check_eq("single_count", 64'(count), 64'd1);
        check_eq("single_pc", 64'(out1_pc), 64'h40);
        check_eq("single_v2", 64'(out2_valid), 64'd0);
        cycle(0, 1, 32'h0, 32'h50, 2'd0, 0);
        check_eq("slot2_only_count", 64'(count), 64'd1);

        // random traffic with occasional flush and mid-run reset
        for (int i = 0; i < 3000; i++) begin
            bit v1 = ($urandom_range(0, 3) != 0);
            bit v2 = 1'($urandom);
            bit fl = ($urandom_range(0, 63) == 0);
            cycle(v1, v2, $urandom, $urandom, 2'($urandom), fl);
            if ($urandom_range(0, 499) == 0) do_reset($urandom_range(1, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
